msx_reset_clkgen: RTL

Stage directly downstream of the PLL. It consumes the PLL lock output and runs on the divided PLL clock (42.95 MHz, clkout/3). It holds the core in reset until lock is stable and filters the cartridge-slot bus reset. It then generates the 3.58 MHz and 1.79 MHz clock-enable pulses used by the Z80/PSG/SCC logic, so no logic runs on the PLL's unstable output.

---
 rtl/msx_reset_clkgen_if.sv | 28 ++
 rtl/msx_reset_clkgen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/msx_reset_clkgen_if.sv
// Signal bundle between the PLL/slot side and the reset/clock-enable generator.
// The master drives lock and slot reset and observes the generated reset and enables.
interface msx_reset_clkgen_if;
  logic pll_lock;
  logic slot_n_reset;
  logic sys_n_reset;
  logic clk_en_3m58;
  logic clk_en_1m79;
  logic pll_ready;

  modport master (
    output pll_lock,
    output slot_n_reset,
    input  sys_n_reset,
    input  clk_en_3m58,
    input  clk_en_1m79,
    input  pll_ready
  );

  modport slave (
    input  pll_lock,
    input  slot_n_reset,
    output sys_n_reset,
    output clk_en_3m58,
    output clk_en_1m79,
    output pll_ready
  );
endinterface

// File: rtl/msx_reset_clkgen.sv
// Reset sequencer and clock-enable generator that sits behind the PLL.
// The core is held in reset until PLL lock has been stable for a qualification
// window and the cartridge-slot /RESET is filtered inactive. Once released, the
// 3.58 MHz and 1.79 MHz enable pulses are derived from the 42.95 MHz clock.
module msx_reset_clkgen #(
  parameter int LOCK_STABLE_CYCLES = 4096,
  parameter int DIV_3M58           = 12,
  parameter int BUS_RST_FILTER     = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  msx_reset_clkgen_if.slave bus
);

  localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES);
  localparam int DIV_W    = $clog2(DIV_3M58);
  localparam int FILT_W   = $clog2(BUS_RST_FILTER + 1);

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(DIV_3M58 - 1);
  localparam logic [FILT_W-1:0]   FILT_LAST   = FILT_W'(BUS_RST_FILTER - 1);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  logic                lock_meta_q, lock_s_q;
  logic                slot_meta_q, slot_s_q;
  logic [1:0]          state_q, state_d;
  logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
  logic                slot_filt_q, slot_filt_d;
  logic [FILT_W-1:0]   filt_cnt_q, filt_cnt_d;
  logic                sys_n_reset_q, sys_n_reset_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                phase_q, phase_d;
  logic                clk_en_3m58_q, clk_en_3m58_d;
  logic                clk_en_1m79_q, clk_en_1m79_d;
  logic                release_hold;

  // Lock qualification FSM: wait for lock, count a stable window, then run.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        stable_cnt_d = '0;
        if (lock_s_q) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lock_s_q) begin
          state_d      = ST_WAIT_LOCK;
          stable_cnt_d = '0;
        end else if (stable_cnt_q == STABLE_LAST) begin
          state_d      = ST_RUN;
          stable_cnt_d = '0;
        end else begin
          stable_cnt_d = stable_cnt_q + STABLE_W'(1);
        end
      end
      ST_RUN: begin
        stable_cnt_d = '0;
        if (!lock_s_q) state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d      = ST_WAIT_LOCK;
        stable_cnt_d = '0;
      end
    endcase
  end

  // Slot reset filter: flip the filtered level only after a run of differing samples.
  always_comb begin
    slot_filt_d = slot_filt_q;
    filt_cnt_d  = '0;
    if (slot_s_q != slot_filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        slot_filt_d = slot_s_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
    end
  end

  // Core reset release and enable divider; the divider and phase stay cleared
  // whenever reset is held or about to be reasserted, so no partial pulse leaks out.
  always_comb begin
    sys_n_reset_d = (state_q == ST_RUN) && slot_filt_q;
    release_hold  = !sys_n_reset_q || !sys_n_reset_d;
    clk_en_3m58_d = !release_hold && (div_cnt_q == DIV_LAST);
    clk_en_1m79_d = clk_en_3m58_d && phase_q;
    if (release_hold) begin
      div_cnt_d = '0;
      phase_d   = 1'b0;
    end else begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
      phase_d   = clk_en_3m58_d ? !phase_q : phase_q;
    end
  end

  // State registers, including the two-stage synchronizers for lock and slot reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      slot_meta_q   <= 1'b0;
      slot_s_q      <= 1'b0;
      state_q       <= ST_WAIT_LOCK;
      stable_cnt_q  <= '0;
      slot_filt_q   <= 1'b0;
      filt_cnt_q    <= '0;
      sys_n_reset_q <= 1'b0;
      div_cnt_q     <= '0;
      phase_q       <= 1'b0;
      clk_en_3m58_q <= 1'b0;
      clk_en_1m79_q <= 1'b0;
    end else begin
      lock_meta_q   <= bus.pll_lock;
      lock_s_q      <= lock_meta_q;
      slot_meta_q   <= bus.slot_n_reset;
      slot_s_q      <= slot_meta_q;
      state_q       <= state_d;
      stable_cnt_q  <= stable_cnt_d;
      slot_filt_q   <= slot_filt_d;
      filt_cnt_q    <= filt_cnt_d;
      sys_n_reset_q <= sys_n_reset_d;
      div_cnt_q     <= div_cnt_d;
      phase_q       <= phase_d;
      clk_en_3m58_q <= clk_en_3m58_d;
      clk_en_1m79_q <= clk_en_1m79_d;
    end
  end

  assign bus.sys_n_reset = sys_n_reset_q;
  assign bus.clk_en_3m58 = clk_en_3m58_q;
  assign bus.clk_en_1m79 = clk_en_1m79_q;
  assign bus.pll_ready   = (state_q == ST_RUN);

endmodule
